// File: rtl/mem_stage_pkg.sv
// Shared load/store funct3 codes, FSM state type and access-fault check
// for the memory stage.
package mem_stage_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Misaligned, undefined-size or read+write access.
  function automatic logic access_fault(
    input logic [2:0] f3,
    input logic [1:0] off,
    input logic       rd_en,
    input logic       wr_en
  );
    logic f;
    f = 1'b0;
    if (rd_en && wr_en)
      f = 1'b1;
    else if (rd_en)
      f = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    else if (wr_en)
      f = (f3 > 3'd2);
    if ((f3[1:0] == 2'b01) && off[0])
      f = 1'b1;
    if ((f3 == LW) && (off != 2'b00))
      f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: picks byte/halfword/word from the read word
// and sign/zero extends. Ports: rdata, offset, funct3 -> data.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (offset)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
  end

  assign h = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    unique case (1'b1)
      (funct3 == LB):  data = {{24{b[7]}}, b};
      (funct3 == LBU): data = {24'd0, b};
      (funct3 == LH):  data = {{16{h[15]}}, h};
      (funct3 == LHU): data = {16'd0, h};
      default:         data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack port, stalls
// upstream while waiting, flags faults. EX inputs -> mem port -> WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] ReadData2,
  input  logic [2:0]      funct3,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            RegWrite,
  input  logic [4:0]      rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_RegWrite,
  output logic            mem_stall,
  output logic            mem_fault
);

  state_t      state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        ld_q;
  logic        rw_q;
  logic [4:0]  rd_q;

  logic        memop;
  logic        fault;
  logic [31:0] wdata_n;
  logic [3:0]  wstrb_n;
  logic [31:0] ld_data;

  assign memop = MemRead | MemWrite;
  assign fault = memop &&
    access_fault(funct3, ALUResult[1:0], MemRead, MemWrite);
  assign mem_stall = (state == WAIT);

  always_comb begin
    wdata_n = ReadData2;
    wstrb_n = 4'b1111;
    unique case (1'b1)
      (funct3 == SB): begin
        wdata_n = {4{ReadData2[7:0]}};
        wstrb_n = 4'b0001 << ALUResult[1:0];
      end
      (funct3 == SH): begin
        wdata_n = {2{ReadData2[15:0]}};
        wstrb_n = 4'b0011 << {ALUResult[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Extraction uses the offset/size captured at issue.
  load_align u_align (
    .rdata  (mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= 4'b0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= 5'd0;
      wb_RegWrite <= 1'b0;
      mem_fault   <= 1'b0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      ld_q        <= 1'b0;
      rw_q        <= 1'b0;
      rd_q        <= 5'd0;
    end else begin
      wb_valid  <= 1'b0;
      mem_fault <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ex_valid) begin
            if (!memop) begin
              wb_valid    <= 1'b1;
              wb_data     <= ALUResult;
              wb_rd       <= rd;
              wb_RegWrite <= RegWrite;
            end else if (fault) begin
              wb_valid    <= 1'b1;
              wb_data     <= ALUResult;
              wb_rd       <= rd;
              wb_RegWrite <= 1'b0;
              mem_fault   <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {ALUResult[31:2], 2'b00};
              mem_wdata <= MemWrite ? wdata_n : '0;
              mem_wstrb <= MemWrite ? wstrb_n : 4'b0;
              off_q     <= ALUResult[1:0];
              f3_q      <= funct3;
              ld_q      <= MemRead;
              rw_q      <= RegWrite;
              rd_q      <= rd;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            state       <= IDLE;
            wb_valid    <= 1'b1;
            wb_data     <= ld_q ? ld_data : '0;
            wb_rd       <= rd_q;
            wb_RegWrite <= ld_q & rw_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard queue.
// Expected results are pushed at issue and popped at completion.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ALUResult;
  logic [31:0] ReadData2;
  logic [2:0]  funct3;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_RegWrite;
  logic        mem_stall;
  logic        mem_fault;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ALUResult   (ALUResult),
    .ReadData2   (ReadData2),
    .funct3      (funct3),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .RegWrite    (RegWrite),
    .rd          (rd),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .wb_RegWrite (wb_RegWrite),
    .mem_stall   (mem_stall),
    .mem_fault   (mem_fault)
  );

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rd;
    logic        rw;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic        v,
                       input logic [31:0] alu,
                       input logic [31:0] rd2,
                       input logic [2:0]  f3,
                       input logic        mr,
                       input logic        mw,
                       input logic        rw,
                       input logic [4:0]  d);
    ex_valid  = v;
    ALUResult = alu;
    ReadData2 = rd2;
    funct3    = f3;
    MemRead   = mr;
    MemWrite  = mw;
    RegWrite  = rw;
    rd        = d;
  endtask

  task automatic idle_in;
    drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic push(input logic [31:0] data,
                      input logic        cd,
                      input logic [4:0]  d,
                      input logic        rw,
                      input logic        f);
    exp_t e;
    e.data     = data;
    e.chk_data = cd;
    e.rd       = d;
    e.rw       = rw;
    e.fault    = f;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
    checks++;
    assert (sb_q.size() != 0) else begin
      failures++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
      chk({tag, ".wb_RegWrite"}, {31'd0, wb_RegWrite},
          {31'd0, e.rw});
      chk({tag, ".mem_fault"}, {31'd0, mem_fault},
          {31'd0, e.fault});
      if (e.chk_data)
        chk({tag, ".wb_data"}, wb_data, e.data);
    end
  endtask

  // n WAIT cycles, ack presented on the last one.
  task automatic wait_ack(input string tag,
                          input int n,
                          input logic [31:0] rdata);
    for (int k = 1; k <= n; k++) begin
      chk({tag, ".stall"}, {31'd0, mem_stall}, 32'd1);
      chk({tag, ".req"}, {31'd0, mem_req}, 32'd1);
      chk({tag, ".wb_idle"}, {31'd0, wb_valid}, 32'd0);
      if (k == n) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      tick();
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
  endtask

  initial begin
    int cnt;
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    drive(1'b1, 32'h55, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd1);
    tick();
    tick();
    chk("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst.stall", {31'd0, mem_stall}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.mem_fault", {31'd0, mem_fault}, 32'd0);
    idle_in();
    rst = 1'b0;
    tick();

    // ALU op
    drive(1'b1, 32'h1234, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd5);
    push(32'h1234, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    idle_in();
    pop_check("alu");
    chk("alu.mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("alu.once", {31'd0, wb_valid}, 32'd0);

    // lb at 0x103, ack on third WAIT cycle
    drive(1'b1, 32'h103, 32'd0, LB, 1'b1, 1'b0, 1'b1, 5'd7);
    push(32'hFFFF_FF80, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    idle_in();
    chk("lb.addr", mem_addr, 32'h100);
    chk("lb.we", {31'd0, mem_we}, 32'd0);
    wait_ack("lb", 3, 32'h80FF_FF7F);
    pop_check("lb");
    chk("lb.req_drop", {31'd0, mem_req}, 32'd0);
    chk("lb.stall_drop", {31'd0, mem_stall}, 32'd0);
    tick();

    // lbu at 0x101
    drive(1'b1, 32'h101, 32'd0, LBU, 1'b1, 1'b0, 1'b1, 5'd8);
    push(32'h0000_00FF, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    idle_in();
    wait_ack("lbu", 1, 32'h80FF_FF7F);
    pop_check("lbu");
    tick();

    // sh at 0x202
    drive(1'b1, 32'h202, 32'hAAAA_BEEF, SH, 1'b0, 1'b1, 1'b1,
          5'd9);
    push(32'd0, 1'b0, 5'd9, 1'b0, 1'b0);
    tick();
    idle_in();
    chk("sh.we", {31'd0, mem_we}, 32'd1);
    chk("sh.addr", mem_addr, 32'h200);
    chk("sh.wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("sh.wstrb", {28'd0, mem_wstrb}, 32'hC);
    wait_ack("sh", 2, 32'h1234_5678);
    pop_check("sh");
    tick();

    // sb at 0x601
    drive(1'b1, 32'h601, 32'h1234_565A, SB, 1'b0, 1'b1, 1'b0,
          5'd2);
    push(32'd0, 1'b0, 5'd2, 1'b0, 1'b0);
    tick();
    idle_in();
    chk("sb.wdata", mem_wdata, 32'h5A5A_5A5A);
    chk("sb.wstrb", {28'd0, mem_wstrb}, 32'h2);
    chk("sb.addr", mem_addr, 32'h600);
    wait_ack("sb", 1, 32'd0);
    pop_check("sb");
    tick();

    // lh at 0x702, signed upper half
    drive(1'b1, 32'h702, 32'd0, LH, 1'b1, 1'b0, 1'b1, 5'd12);
    push(32'hFFFF_8001, 1'b1, 5'd12, 1'b1, 1'b0);
    tick();
    idle_in();
    wait_ack("lh", 1, 32'h8001_0000);
    pop_check("lh");
    tick();

    // lw at 0x301: misaligned fault
    drive(1'b1, 32'h301, 32'd0, LW, 1'b1, 1'b0, 1'b1, 5'd3);
    push(32'd0, 1'b0, 5'd3, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("lwf.req", {31'd0, mem_req}, 32'd0);
    chk("lwf.stall", {31'd0, mem_stall}, 32'd0);
    pop_check("lwf");
    tick();
    chk("lwf.pulse", {31'd0, mem_fault}, 32'd0);
    chk("lwf.wb_off", {31'd0, wb_valid}, 32'd0);
    chk("lwf.req2", {31'd0, mem_req}, 32'd0);

    // read and write together: fault
    drive(1'b1, 32'h800, 32'd0, LW, 1'b1, 1'b1, 1'b1, 5'd6);
    push(32'd0, 1'b0, 5'd6, 1'b0, 1'b1);
    tick();
    idle_in();
    chk("rwf.req", {31'd0, mem_req}, 32'd0);
    pop_check("rwf");
    tick();

    // reset in second WAIT cycle, late ack ignored
    drive(1'b1, 32'h500, 32'd0, LW, 1'b1, 1'b0, 1'b1, 5'd4);
    tick();
    idle_in();
    chk("rstw.stall1", {31'd0, mem_stall}, 32'd1);
    tick();
    chk("rstw.stall2", {31'd0, mem_stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw.req", {31'd0, mem_req}, 32'd0);
    chk("rstw.stall", {31'd0, mem_stall}, 32'd0);
    chk("rstw.wb", {31'd0, wb_valid}, 32'd0);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    chk("rstw.ack_wb", {31'd0, wb_valid}, 32'd0);
    chk("rstw.ack_req", {31'd0, mem_req}, 32'd0);
    chk("rstw.ack_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    chk("rstw.ack_wb2", {31'd0, wb_valid}, 32'd0);

    // lhu then ALU held by stall
    drive(1'b1, 32'h402, 32'd0, LHU, 1'b1, 1'b0, 1'b1, 5'd10);
    push(32'h0000_9876, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hCAFE, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd11);
    push(32'hCAFE, 1'b1, 5'd11, 1'b1, 1'b0);
    wait_ack("lhu", 2, 32'h9876_5432);
    pop_check("lhu");
    tick();
    idle_in();
    pop_check("held_alu");
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (wb_valid) cnt++;
    end
    chk("held_alu.once", cnt, 32'd0);

    chk("sb.empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
